// File: rtl/ysyx_22040386_lsu_pkg.sv
// ysyx_22040386_lsu_pkg: access-size encodings, FSM state codes and strobe constants shared by the LSU
package ysyx_22040386_lsu_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0f;
  localparam logic [7:0] STRB_D = 8'hff;
  function automatic logic [7:0] size_strb(input logic [1:0] sz);
    return sz == 2'd0 ? STRB_B : sz == 2'd1 ? STRB_H : sz == 2'd2 ? STRB_W : STRB_D;
  endfunction
endpackage

// File: rtl/ysyx_22040386_lsu_align.sv
// ysyx_22040386_lsu_align: store lane shift/strobes, misalign detect (st_*), load extract/extend (ld_*)
module ysyx_22040386_lsu_align
  import ysyx_22040386_lsu_pkg::*;
(
  input  logic [2:0]  st_off_i,
  input  logic [2:0]  st_mask_i,
  input  logic [63:0] st_data_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_off_i,
  input  logic [2:0]  ld_mask_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] ldata_o
);
  logic [2:0]  lo;
  logic [63:0] lane;
  // offset bits that must be zero for the access size: b 000, h 001, w 011, d 111
  assign lo = {&st_mask_i[1:0], st_mask_i[1], |st_mask_i[1:0]};
  assign misalign_o = (st_mask_i == 3'b111) | (|(st_off_i & lo));
  assign wdata_o = st_data_i << {st_off_i, 3'b000};
  assign wstrb_o = size_strb(st_mask_i[1:0]) << st_off_i;
  assign lane = rdata_i >> {ld_off_i, 3'b000};
  assign ldata_o = ld_mask_i == LSU_B  ? {{56{lane[7]}}, lane[7:0]}
                 : ld_mask_i == LSU_H  ? {{48{lane[15]}}, lane[15:0]}
                 : ld_mask_i == LSU_W  ? {{32{lane[31]}}, lane[31:0]}
                 : ld_mask_i == LSU_BU ? {56'd0, lane[7:0]}
                 : ld_mask_i == LSU_HU ? {48'd0, lane[15:0]}
                 : ld_mask_i == LSU_WU ? {32'd0, lane[31:0]}
                 : lane;
endmodule

// File: rtl/ysyx_22040386_lsu.sv
// ysyx_22040386_lsu: MEM stage; runs one valid/ready dmem transaction per load/store and stalls the pipe until it completes
module ysyx_22040386_lsu
  import ysyx_22040386_lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int RSP_TIMEOUT = 256
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_MEM_valid,
  input  logic [XLEN-1:0] i_MEM_ALUresult,
  input  logic [XLEN-1:0] i_MEM_mem_wr_data,
  input  logic [2:0]      i_MEM_mem_mask,
  input  logic            i_MEM_MemRead,
  input  logic            i_MEM_MemWrite,
  input  logic [XLEN-1:0] i_MEM_reg_wr_data,
  output logic [XLEN-1:0] o_MEM_reg_wr_data,
  output logic            o_MEM_stall,
  output logic            o_MEM_misalign,
  output logic            o_MEM_bus_err,
  output logic            o_dmem_req_valid,
  input  logic            i_dmem_req_ready,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic            o_dmem_wen,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [7:0]      o_dmem_wstrb,
  input  logic            i_dmem_rsp_valid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  input  logic            i_dmem_rsp_err
);
  localparam int CW = $clog2(RSP_TIMEOUT);
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     addr_q, wdata_q, rdata_q, st_wdata, ldata;
  logic [7:0]      wstrb_q, st_wstrb;
  logic [2:0]      mask_q;
  logic            wen_q, err_q, acc, wr, mis, go, idle, timeout;
  assign acc = i_MEM_valid & (i_MEM_MemRead | i_MEM_MemWrite);
  // read wins when both controls are set
  assign wr = i_MEM_MemWrite & ~i_MEM_MemRead;
  assign idle = state_q == S_IDLE;
  assign go = idle & acc & ~mis;
  assign timeout = cnt_q == CW'(RSP_TIMEOUT - 1);
  ysyx_22040386_lsu_align u_align (
    .st_off_i   (i_MEM_ALUresult[2:0]),
    .st_mask_i  (i_MEM_mem_mask),
    .st_data_i  (i_MEM_mem_wr_data),
    .wdata_o    (st_wdata),
    .wstrb_o    (st_wstrb),
    .misalign_o (mis),
    .ld_off_i   (addr_q[2:0]),
    .ld_mask_i  (mask_q),
    .rdata_i    (i_dmem_rdata),
    .ldata_o    (ldata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: state_d = go ? S_REQ : S_IDLE;
      S_REQ: begin
        state_d = i_dmem_req_ready ? S_RESP : S_REQ;
        cnt_d = i_dmem_req_ready ? '0 : cnt_q;
      end
      S_RESP: begin
        state_d = (i_dmem_rsp_valid | timeout) ? S_DONE : S_RESP;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mask_q <= '0;
      wen_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (go) begin
        addr_q <= i_MEM_ALUresult;
        wdata_q <= st_wdata;
        wstrb_q <= wr ? st_wstrb : 8'h00;
        mask_q <= i_MEM_mem_mask;
        wen_q <= wr;
      end
      if (state_q == S_RESP && (i_dmem_rsp_valid || timeout)) begin
        rdata_q <= (i_dmem_rsp_valid && !i_dmem_rsp_err) ? ldata : '0;
        err_q <= i_dmem_rsp_valid ? i_dmem_rsp_err : 1'b1;
      end
    end
  end
  // combinational outputs are forced low while reset is held so the pipe sees a quiet MEM stage
  assign o_MEM_stall = i_rst_n & (go | state_q == S_REQ | state_q == S_RESP);
  assign o_MEM_misalign = i_rst_n & idle & acc & mis;
  assign o_MEM_bus_err = state_q == S_DONE & err_q;
  assign o_MEM_reg_wr_data = !i_rst_n ? '0
                           : state_q == S_DONE ? (wen_q ? i_MEM_reg_wr_data : rdata_q)
                           : (idle & ~(acc & mis)) ? i_MEM_reg_wr_data
                           : '0;
  assign o_dmem_req_valid = state_q == S_REQ;
  assign o_dmem_addr = {addr_q[63:3], 3'b000};
  assign o_dmem_wen = wen_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wstrb = wstrb_q;
endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// tb_ysyx_22040386_lsu: directed self-checking bench for the MEM-stage LSU
module tb_ysyx_22040386_lsu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 1'b0, rd = 1'b0, wr = 1'b0, ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [63:0] addr = '0, wdat = '0, regin = '0, rdata = '0;
  logic [2:0]  mask = '0;
  logic [63:0] reg_out, dmem_addr, dmem_wdata;
  logic        stall, misalign, bus_err, req_valid, wen;
  logic [7:0]  wstrb;
  int checks = 0, errors = 0, n;

  ysyx_22040386_lsu dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_MEM_valid(valid), .i_MEM_ALUresult(addr),
    .i_MEM_mem_wr_data(wdat), .i_MEM_mem_mask(mask), .i_MEM_MemRead(rd), .i_MEM_MemWrite(wr),
    .i_MEM_reg_wr_data(regin), .o_MEM_reg_wr_data(reg_out), .o_MEM_stall(stall),
    .o_MEM_misalign(misalign), .o_MEM_bus_err(bus_err), .o_dmem_req_valid(req_valid),
    .i_dmem_req_ready(ready), .o_dmem_addr(dmem_addr), .o_dmem_wen(wen), .o_dmem_wdata(dmem_wdata),
    .o_dmem_wstrb(wstrb), .i_dmem_rsp_valid(rsp_valid), .i_dmem_rdata(rdata), .i_dmem_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] m, input logic [63:0] a, input logic [63:0] rdv, input logic [63:0] exp);
    valid = 1; rd = 1; wr = 0; mask = m; addr = a; regin = 64'h1234; ready = 1;
    #1 chk({tag, "_idle_stall"}, stall, 1);
    tick;
    chk({tag, "_req"}, req_valid, 1);
    tick;
    rsp_valid = 1; rdata = rdv;
    tick;
    rsp_valid = 0;
    chk({tag, "_data"}, reg_out, exp);
    chk({tag, "_stall"}, stall, 0);
    valid = 0; rd = 0;
    tick;
  endtask

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_req", req_valid, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_reg", reg_out, 0);
    chk("rst_err", bus_err, 0);
    tick;
    rst_n = 1;
    regin = 64'hCAFE;
    #1 chk("idle_pass", reg_out, 64'hCAFE);
    tick;
    // 1: ld, response in the second RESP cycle
    valid = 1; rd = 1; mask = 3'b011; addr = 64'h80000008; ready = 1;
    #1 chk("ld_stall_idle", stall, 1);
    tick;
    chk("ld_stall_req", stall, 1);
    chk("ld_req_valid", req_valid, 1);
    chk("ld_addr", dmem_addr, 64'h80000008);
    chk("ld_wen", wen, 0);
    chk("ld_wstrb", wstrb, 0);
    tick;
    chk("ld_stall_resp1", stall, 1);
    chk("ld_req_drop", req_valid, 0);
    tick;
    chk("ld_stall_resp2", stall, 1);
    rsp_valid = 1; rdata = 64'h1122334455667788;
    tick;
    rsp_valid = 0;
    chk("ld_done_stall", stall, 0);
    chk("ld_done_data", reg_out, 64'h1122334455667788);
    chk("ld_done_err", bus_err, 0);
    valid = 0; rd = 0;
    tick;
    // 2: sub-word loads
    do_load("lb", 3'b000, 64'h80000003, 64'h0000000080FF0000, 64'hFFFFFFFFFFFFFF80);
    do_load("lbu", 3'b100, 64'h80000003, 64'h0000000080FF0000, 64'h0000000000000080);
    do_load("lh", 3'b001, 64'h80000002, 64'h0000000080010000, 64'hFFFFFFFFFFFF8001);
    do_load("lwu", 3'b110, 64'h80000004, 64'hF000000100000000, 64'h00000000F0000001);
    do_load("lw", 3'b010, 64'h80000004, 64'hF000000100000000, 64'hFFFFFFFFF0000001);
    // 3: sh at offset 6
    valid = 1; wr = 1; rd = 0; mask = 3'b001; addr = 64'h80000006; wdat = 64'hABCD; regin = 64'h55;
    #1 chk("sh_stall", stall, 1);
    tick;
    chk("sh_wdata", dmem_wdata, 64'hABCD000000000000);
    chk("sh_wstrb", wstrb, 8'hC0);
    chk("sh_wen", wen, 1);
    chk("sh_addr", dmem_addr, 64'h80000000);
    tick;
    rsp_valid = 1; rdata = 64'h9999999999999999;
    tick;
    rsp_valid = 0;
    chk("sh_done_reg", reg_out, 64'h55);
    chk("sh_done_stall", stall, 0);
    valid = 0; wr = 0;
    tick;
    // 4: misaligned / illegal
    valid = 1; rd = 1; mask = 3'b010; addr = 64'h80000002; regin = 64'h77;
    #1 chk("mis_flag", misalign, 1);
    chk("mis_stall", stall, 0);
    chk("mis_reg", reg_out, 0);
    tick;
    chk("mis_noreq", req_valid, 0);
    chk("mis_flag2", misalign, 1);
    mask = 3'b111; addr = 64'h80000000;
    #1 chk("ill_flag", misalign, 1);
    chk("ill_stall", stall, 0);
    valid = 0;
    #1 chk("noacc_mis", misalign, 0);
    tick;
    // 5: slow request acceptance, early responses ignored, error response
    valid = 1; rd = 1; mask = 3'b011; addr = 64'h80000010; ready = 0; rdata = 64'hFFFF;
    tick;
    rsp_valid = 1; rsp_err = 0;
    for (int i = 0; i < 5; i++) begin
      chk("err_req_valid", req_valid, 1);
      chk("err_req_addr", dmem_addr, 64'h80000010);
      chk("err_req_wen", wen, 0);
      tick;
    end
    ready = 1;
    chk("err_hs_valid", req_valid, 1);
    tick;
    ready = 0; rsp_valid = 0;
    chk("err_resp_stall", stall, 1);
    tick;
    chk("err_resp_hold", stall, 1);
    chk("err_resp_noerr", bus_err, 0);
    rsp_valid = 1; rsp_err = 1;
    tick;
    rsp_valid = 0; rsp_err = 0;
    chk("err_done_err", bus_err, 1);
    chk("err_done_data", reg_out, 0);
    chk("err_done_stall", stall, 0);
    valid = 0; rd = 0;
    tick;
    chk("err_pulse_end", bus_err, 0);
    // 6: timeout
    valid = 1; rd = 1; mask = 3'b011; addr = 64'h80000018; ready = 1;
    tick;
    tick;
    n = 0;
    while (stall && n < 300) begin
      tick;
      n++;
    end
    chk("to_cycles", 64'(n), 64'd256);
    chk("to_err", bus_err, 1);
    chk("to_data", reg_out, 0);
    valid = 0; rd = 0;
    tick;
    // reset during RESP
    valid = 1; rd = 1; mask = 3'b011; addr = 64'h80000020; ready = 1; regin = 64'h77;
    tick;
    tick;
    tick;
    chk("rr_in_resp", stall, 1);
    rst_n = 0;
    #1 chk("rr_stall", stall, 0);
    chk("rr_req", req_valid, 0);
    chk("rr_addr", dmem_addr, 0);
    chk("rr_wstrb", wstrb, 0);
    chk("rr_reg", reg_out, 0);
    chk("rr_err", bus_err, 0);
    valid = 0; rd = 0;
    tick;
    rst_n = 1; rsp_valid = 1; rdata = 64'hDEAD;
    tick;
    rsp_valid = 0;
    chk("rr_late_stall", stall, 0);
    chk("rr_late_err", bus_err, 0);
    chk("rr_late_reg", reg_out, 64'h77);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22040386_lsu.md
Name: ysyx_22040386_lsu

Overview:
Memory-access (MEM) stage, directly downstream of the execute stage. It consumes the EX/MEM-registered ALU result (used as the address), store data, access mask and MemRead/MemWrite controls. It then runs a valid/ready transaction on the 64-bit data-memory bus, aligns and extends load data, and stalls the pipeline until the access completes. Non-memory instructions pass through with zero added latency.

Parameters:
XLEN, 64, datapath and address width; only 64 is supported.
RSP_TIMEOUT, 256, maximum number of cycles spent in RESP before the access is forced to complete with a bus error.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
i_MEM_valid  input  1  the instruction in MEM is valid.
i_MEM_ALUresult  input  64  byte address.
i_MEM_mem_wr_data  input  64  store data, right-aligned.
i_MEM_mem_mask  input  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal.
i_MEM_MemRead  input  1  load.
i_MEM_MemWrite  input  1  store.
i_MEM_reg_wr_data  input  64  non-load writeback value from EX.
o_MEM_reg_wr_data  output  64  writeback value.
o_MEM_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
o_MEM_misalign  output  1  address/size misaligned or mask illegal.
o_MEM_bus_err  output  1  error response or timeout; 1-cycle pulse.
o_dmem_req_valid  output  1  request valid.
i_dmem_req_ready  input  1  request accepted.
o_dmem_addr  output  64  address aligned to 8 (bits [2:0] = 0).
o_dmem_wen  output  1  1 = write.
o_dmem_wdata  output  64  lane-shifted store data.
o_dmem_wstrb  output  8  byte strobes.
i_dmem_rsp_valid  input  1  response valid.
i_dmem_rdata  input  64  read data, full doubleword.
i_dmem_rsp_err  input  1  response error, qualified by rsp_valid.

Behaviour:
- Reset (async, i_rst_n = 0):
  - state = IDLE; timeout counter = 0.
  - All registered outputs and o_dmem_* = 0.
  - o_MEM_stall = 0.
- acc = i_MEM_valid & (MemRead | MemWrite). If both MemRead and MemWrite are set, the access is a read.
- size = 1, 2, 4 or 8 bytes from mask[1:0]. Misaligned when addr[2:0] mod size != 0, or when mask = 111.
- Misaligned access:
  - o_MEM_misalign = 1, combinational, in IDLE.
  - No bus request; no stall; o_MEM_reg_wr_data = 0.
- FSM IDLE -> REQ -> RESP -> DONE -> IDLE:
  - IDLE:
    - If acc and aligned: capture address, shifted wdata, wstrb, mask and wen; go to REQ. o_MEM_stall = 1 in this cycle.
    - Otherwise: o_MEM_stall = 0 and o_MEM_reg_wr_data = i_MEM_reg_wr_data.
  - REQ:
    - o_dmem_req_valid = 1, and request fields stay stable until handshake.
    - On req_valid & req_ready, go to RESP and clear the counter.
    - stall = 1.
  - RESP:
    - req_valid = 0. The counter increments each cycle.
    - A response arriving in the REQ cycle, or in the handshake cycle itself, is ignored. The earliest legal response is the cycle after the handshake.
    - On rsp_valid: capture the load result and rsp_err, then go to DONE.
    - If the counter reaches RSP_TIMEOUT-1 without a response: go to DONE with error set.
    - stall = 1.
  - DONE:
    - stall = 0, so the pipeline advances at this edge.
    - o_MEM_reg_wr_data = captured load data for loads, i_MEM_reg_wr_data for stores.
    - o_MEM_bus_err = captured error; on error, load data = 0.
    - Next state: IDLE. The next instruction is evaluated in IDLE on the following cycle, so a back-to-back access costs no extra bubble.
- Store lanes:
  - wdata = data << (8*addr[2:0]).
  - wstrb = (1, 3, F or FF by size) << addr[2:0].
  - Loads drive wstrb = 0 and wen = 0.
- Load data:
  - lane = rdata >> (8*addr[2:0]); truncate to size.
  - Sign-extend for 000/001/010; zero-extend for 100/101/110; 011 passes through.
- Reset mid-transaction: returns to IDLE immediately and drops req_valid. A late response is ignored in IDLE.

Decomposition:
- Shared package holds:
  - mask encodings (LSU_B … LSU_WU);
  - FSM state encoding (IDLE = 0, REQ = 1, RESP = 2, DONE = 3);
  - strobe constants.
- One natural combinational sub-module, ysyx_22040386_lsu_align:
  - store lane shift and wstrb;
  - load extract and extend;
  - misalign detection.
- The FSM and counter stay in the top-level module.

Test Plan:
1. ld at 0x80000008, req_ready = 1 immediately, response 2 cycles later with rdata 0x1122334455667788:
   - stall high for 4 cycles (IDLE, REQ, RESP, RESP);
   - DONE cycle outputs 0x1122334455667788;
   - o_dmem_addr = 0x80000008.
2. lb at 0x80000003, rdata 0x00000000_80FF0000:
   - lane byte 0x80, result 0xFFFFFFFFFFFFFF80;
   - same with lbu -> 0x80.
3. sh at 0x80000006, data 0xABCD:
   - wdata = 0xABCD000000000000, wstrb = 0xC0, wen = 1;
   - reg_wr_data = passthrough.
4. lw at 0x80000002:
   - o_MEM_misalign = 1, o_dmem_req_valid stays 0, stall 0.
5. req_ready held low 5 cycles, then response with rsp_err = 1:
   - req fields stable throughout REQ;
   - o_MEM_bus_err pulses 1 cycle in DONE, data 0.
6. Response never arrives:
   - DONE after RSP_TIMEOUT cycles with bus_err = 1.
   - Separately, assert i_rst_n low during RESP: state returns to IDLE and all outputs go to 0 immediately.
